// File: rtl/char_mem_ctrl_if.sv
// Bus bundle for char_mem_ctrl: video fetch port, host write port,
// clear-screen command/status and the single-port RAM port.
// The slave modport is the controller. The master modport is everything
// around it: the video engine, the host and the RAM.
//
// Host write handshake: host_wr_valid is the offer and host_wr_ready is
// the controller's combinational grant for the current cycle. A transfer
// happens in every cycle where both are high. The host holds address and
// data stable while valid is high and not yet granted. The video port
// has no back-pressure: each vid_req cycle is one fetch.
interface char_mem_ctrl_if #(
    parameter int ADDR_W = 14
);
    logic              vid_req;
    logic [ADDR_W-1:0] vid_addr;
    logic [7:0]        vid_data;
    logic              vid_valid;
    logic              host_wr_valid;
    logic              host_wr_ready;
    logic [ADDR_W-1:0] host_wr_addr;
    logic [7:0]        host_wr_data;
    logic              cls_start;
    logic              cls_busy;
    logic              cls_done;
    logic [7:0]        drop_cnt;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic [7:0]        mem_rdata;

    modport master (
        output vid_req, vid_addr, host_wr_valid, host_wr_addr, host_wr_data,
               cls_start, mem_rdata,
        input  vid_data, vid_valid, host_wr_ready, cls_busy, cls_done,
               drop_cnt, mem_en, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  vid_req, vid_addr, host_wr_valid, host_wr_addr, host_wr_data,
               cls_start, mem_rdata,
        output vid_data, vid_valid, host_wr_ready, cls_busy, cls_done,
               drop_cnt, mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/char_mem_ctrl.sv
// Character-cell memory controller. It arbitrates one single-port RAM
// between video fetches (highest priority), the clear-screen sequencer
// and host writes (lowest priority).
// Optional feature macro: CHAR_MEM_CLS_EN enables the clear sequencer.
// Without it, cls_start is ignored and cls_busy/cls_done stay low.
module char_mem_ctrl #(
    parameter int         COLS      = 160,
    parameter int         ROWS      = 60,
    parameter int         ADDR_W    = 14,
    parameter logic [7:0] FILL_CHAR = 8'h20
) (
    input logic            clk,
    input logic            clr,
    char_mem_ctrl_if.slave bus
);
    localparam int                NCELLS   = COLS * ROWS;
    localparam logic [ADDR_W:0]   NCELLS_W = (ADDR_W+1)'(NCELLS);

    logic              w_vid_in_rng;
    logic              w_host_in_rng;
    logic              w_vid_acc;
    logic              w_host_xfer;
    logic              w_host_acc;
    logic              w_drop;
    logic              w_idle;
    logic              w_cls_block;
    logic              w_clr_acc;
    logic [ADDR_W-1:0] w_clr_addr;
    logic              w_acc;
    logic              w_we;
    logic [ADDR_W-1:0] w_addr;
    logic [7:0]        w_wdata;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [7:0]        r_mem_wdata;
    logic              r_v1_valid;
    logic              r_v1_in_rng;
    logic              r_vid_valid;
    logic [7:0]        r_vid_data;
    logic [7:0]        r_drop_cnt;

    assign w_vid_in_rng  = {1'b0, bus.vid_addr} < NCELLS_W;
    assign w_host_in_rng = {1'b0, bus.host_wr_addr} < NCELLS_W;

    // Video always wins the RAM. Out-of-range fetches skip the RAM but still
    // travel down the pipe so that every request gets exactly one response.
    assign w_vid_acc = bus.vid_req && w_vid_in_rng && !clr;

`ifdef CHAR_MEM_CLS_EN
    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_CLEAR = 1'b1
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_CELL = ADDR_W'(NCELLS - 1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_ptr;
    logic [ADDR_W-1:0] w_ptr_nxt;
    logic              r_cls_done;
    logic              w_cls_done_nxt;

    // Clear sequencer state, fill pointer and the registered done pulse.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_state    <= S_IDLE;
            r_ptr      <= '0;
            r_cls_done <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_ptr      <= w_ptr_nxt;
            r_cls_done <= w_cls_done_nxt;
        end
    end

    // Next-state logic. A video request stalls the fill for that cycle.
    // The last cell's write returns the FSM to IDLE with a done pulse.
    always_comb begin
        w_state_nxt    = r_state;
        w_ptr_nxt      = r_ptr;
        w_cls_done_nxt = 1'b0;
        w_clr_acc      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.cls_start) begin
                    w_state_nxt = S_CLEAR;
                    w_ptr_nxt   = '0;
                end
            end
            S_CLEAR: begin
                if (!bus.vid_req) begin
                    w_clr_acc = 1'b1;
                    if (r_ptr == LAST_CELL) begin
                        w_state_nxt    = S_IDLE;
                        w_ptr_nxt      = '0;
                        w_cls_done_nxt = 1'b1;
                    end else begin
                        w_ptr_nxt = r_ptr + ADDR_W'(1);
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign w_idle       = (r_state == S_IDLE);
    assign w_cls_block  = bus.cls_start;
    assign w_clr_addr   = r_ptr;
    assign bus.cls_busy = (r_state == S_CLEAR);
    assign bus.cls_done = r_cls_done;
`else
    logic w_unused_cls;

    assign w_unused_cls = bus.cls_start | (|FILL_CHAR);
    assign w_idle       = 1'b1;
    assign w_cls_block  = 1'b0;
    assign w_clr_acc    = 1'b0;
    assign w_clr_addr   = '0;
    assign bus.cls_busy = 1'b0;
    assign bus.cls_done = 1'b0;
`endif

    // The host gets the RAM only when nobody with higher priority wants it.
    // A clear command in the same cycle also blocks the host.
    assign bus.host_wr_ready = w_idle && !bus.vid_req && !w_cls_block && !clr;
    assign w_host_xfer       = bus.host_wr_valid && bus.host_wr_ready;
    assign w_host_acc        = w_host_xfer && w_host_in_rng;
    assign w_drop            = w_host_xfer && !w_host_in_rng;

    // RAM port mux. When no access happens, the port shows the last address
    // and the last write data.
    always_comb begin
        w_acc   = 1'b0;
        w_we    = 1'b0;
        w_addr  = r_mem_addr;
        w_wdata = r_mem_wdata;
        if (w_vid_acc) begin
            w_acc  = 1'b1;
            w_addr = bus.vid_addr;
        end else if (w_clr_acc) begin
            w_acc   = 1'b1;
            w_we    = 1'b1;
            w_addr  = w_clr_addr;
            w_wdata = FILL_CHAR;
        end else if (w_host_acc) begin
            w_acc   = 1'b1;
            w_we    = 1'b1;
            w_addr  = bus.host_wr_addr;
            w_wdata = bus.host_wr_data;
        end
    end

    // Remember the last driven address and write data so idle cycles hold them.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else begin
            if (w_acc) r_mem_addr <= w_addr;
            if (w_we)  r_mem_wdata <= w_wdata;
        end
    end

    // Two-stage fetch pipe: stage 1 waits for RAM latency, stage 2 captures.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_v1_valid  <= 1'b0;
            r_v1_in_rng <= 1'b0;
            r_vid_valid <= 1'b0;
            r_vid_data  <= 8'h00;
        end else begin
            r_v1_valid  <= bus.vid_req;
            r_v1_in_rng <= w_vid_in_rng;
            r_vid_valid <= r_v1_valid;
            if (r_v1_valid) r_vid_data <= r_v1_in_rng ? bus.mem_rdata : 8'h00;
        end
    end

    // Saturating count of host writes accepted to addresses off the screen.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_drop_cnt <= 8'h00;
        end else if (w_drop && (r_drop_cnt != 8'hFF)) begin
            r_drop_cnt <= r_drop_cnt + 8'd1;
        end
    end

    assign bus.mem_en    = w_acc;
    assign bus.mem_we    = w_we;
    assign bus.mem_addr  = w_addr;
    assign bus.mem_wdata = w_wdata;
    assign bus.vid_data  = r_vid_data;
    assign bus.vid_valid = r_vid_valid;
    assign bus.drop_cnt  = r_drop_cnt;
endmodule

// File: tb/tb_char_mem_ctrl.sv
// Directed bench for char_mem_ctrl with a behavioural 1-cycle RAM and a
// scoreboard for video fetch results and their latency.
module tb_char_mem_ctrl;
    localparam int         ADDR_W = 14;
    localparam int         NCELLS = 9600;
    localparam logic [7:0] FILL   = 8'h20;

    logic clk = 1'b0;
    logic clr;

    char_mem_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

    char_mem_ctrl #(.COLS(160), .ROWS(60), .ADDR_W(ADDR_W), .FILL_CHAR(FILL)) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] pat(int i, logic [7:0] s);
        if (i == 5) return 8'h41;
        return 8'(i * 37) ^ s;
    endfunction

    // Behavioural single-port RAM with a bulk-fill backdoor.
    logic [7:0] ram [0:16383];
    logic [7:0] ram_rdata = 8'h00;
    logic       fill_req;
    logic [7:0] fill_seed;
    assign bus.mem_rdata = ram_rdata;

    always @(posedge clk) begin
        if (fill_req) begin
            for (int i = 0; i < 16384; i++) ram[i] <= pat(i, fill_seed);
        end else if (bus.mem_en) begin
            if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
            else            ram_rdata <= ram[bus.mem_addr];
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Observers: capture fetch responses and track the clear write sequence.
    logic [7:0] obs_data [0:8191];
    int         obs_cyc  [0:8191];
    int         obs_n = 0;
    int         clr_wr_cnt = 0;
    int         clr_seq_err = 0;
    int         busy_cnt = 0;
    int         done_cnt = 0;

    always @(negedge clk) begin
        if (bus.vid_valid && obs_n < 8192) begin
            obs_data[obs_n] = bus.vid_data;
            obs_cyc[obs_n]  = cyc;
            obs_n++;
        end
        if (bus.cls_start && !bus.cls_busy && !clr) begin
            clr_wr_cnt  = 0;
            clr_seq_err = 0;
            busy_cnt    = 0;
            done_cnt    = 0;
        end else begin
            if (bus.cls_busy) busy_cnt++;
            if (bus.cls_done) done_cnt++;
            if (bus.cls_busy && bus.mem_en && bus.mem_we) begin
                if (32'(bus.mem_addr) != clr_wr_cnt || bus.mem_wdata != FILL) clr_seq_err++;
                clr_wr_cnt++;
            end
        end
    end

    int         checks = 0;
    int         errors = 0;
    int         rd_n = 0;
    int         nfetch;
    int         bad;
    int         a;
    logic [7:0] exp_q [$];
    int         expc_q [$];
    logic [7:0] model_mem [0:16383];

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drain();
        while (rd_n < obs_n) begin
            chk("vid_pending", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                chk("vid_data", 32'(obs_data[rd_n]), 32'(exp_q.pop_front()));
                chk("vid_latency", obs_cyc[rd_n], expc_q.pop_front());
            end
            rd_n++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        drain();
    endtask

    task automatic push_fetch(logic [7:0] e);
        exp_q.push_back(e);
        expc_q.push_back(cyc + 2);
    endtask

    function automatic logic [7:0] model_rd(int addr);
        return (addr >= NCELLS) ? 8'h00 : model_mem[addr];
    endfunction

    task automatic reset_checks(string ph);
        chk({ph, "_vid_valid"}, 32'(bus.vid_valid), 0);
        chk({ph, "_vid_data"}, 32'(bus.vid_data), 0);
        chk({ph, "_cls_busy"}, 32'(bus.cls_busy), 0);
        chk({ph, "_cls_done"}, 32'(bus.cls_done), 0);
        chk({ph, "_drop_cnt"}, 32'(bus.drop_cnt), 0);
        chk({ph, "_mem_en"}, 32'(bus.mem_en), 0);
        chk({ph, "_mem_we"}, 32'(bus.mem_we), 0);
        chk({ph, "_mem_addr"}, 32'(bus.mem_addr), 0);
        chk({ph, "_mem_wdata"}, 32'(bus.mem_wdata), 0);
        chk({ph, "_wr_ready"}, 32'(bus.host_wr_ready), 0);
    endtask

    initial begin
        bus.vid_req = 1'b0; bus.vid_addr = '0; bus.host_wr_valid = 1'b0;
        bus.host_wr_addr = '0; bus.host_wr_data = 8'h00; bus.cls_start = 1'b0;
        fill_req = 1'b0; fill_seed = 8'h5A; clr = 1'b1;
        #1;
        reset_checks("reset");
        fill_req = 1'b1;
        tick();
        fill_req = 1'b0;
        for (int i = 0; i < 16384; i++) model_mem[i] = pat(i, 8'h5A);
        tick();
        clr = 1'b0;
        #1;
        chk("ready_after_reset", 32'(bus.host_wr_ready), 1);

        // Single fetch of cell 5, which holds 'A'.
        bus.vid_req = 1'b1; bus.vid_addr = 14'd5; push_fetch(8'h41);
        #1;
        chk("fetch5_mem_en", 32'(bus.mem_en), 1);
        chk("fetch5_mem_we", 32'(bus.mem_we), 0);
        chk("fetch5_mem_addr", 32'(bus.mem_addr), 5);
        tick(); bus.vid_req = 1'b0;
        tick(); tick(); tick();
        chk("fetch5_vid_hold", 32'(bus.vid_data), 32'h41);

        // Back-to-back fetches, including both range edges and off-screen cells.
        for (int i = 0; i < 10; i++) begin
            case (i)
                0: a = 0;
                1: a = NCELLS - 1;
                2: a = NCELLS;
                3: a = 16383;
                default: a = $urandom_range(0, NCELLS - 1);
            endcase
            bus.vid_req = 1'b1; bus.vid_addr = 14'(a); push_fetch(model_rd(a));
            #1;
            chk("b2b_mem_en", 32'(bus.mem_en), 32'(a < NCELLS));
            tick();
        end
        bus.vid_req = 1'b0;
        tick(); tick(); tick();
        chk("b2b_queue_empty", exp_q.size(), 0);

        // Host write collides with a fetch, then goes through the next cycle.
        bus.vid_req = 1'b1; bus.vid_addr = 14'd20; push_fetch(model_rd(20));
        bus.host_wr_valid = 1'b1; bus.host_wr_addr = 14'd10; bus.host_wr_data = 8'h7A;
        #1;
        chk("collide_ready", 32'(bus.host_wr_ready), 0);
        chk("collide_mem_addr", 32'(bus.mem_addr), 20);
        tick(); bus.vid_req = 1'b0;
        #1;
        chk("hwr_ready", 32'(bus.host_wr_ready), 1);
        chk("hwr_mem_we", 32'(bus.mem_we), 1);
        chk("hwr_mem_addr", 32'(bus.mem_addr), 10);
        chk("hwr_mem_wdata", 32'(bus.mem_wdata), 32'h7A);
        tick(); bus.host_wr_valid = 1'b0; model_mem[10] = 8'h7A;
        chk("hwr_ram10", 32'(ram[10]), 32'h7A);
        #1;
        chk("idle_mem_en", 32'(bus.mem_en), 0);
        chk("idle_addr_hold", 32'(bus.mem_addr), 10);
        chk("idle_wdata_hold", 32'(bus.mem_wdata), 32'h7A);
        bus.vid_req = 1'b1; bus.vid_addr = 14'd10; push_fetch(model_rd(10));
        tick(); bus.vid_req = 1'b0;
        tick(); tick(); tick();
        chk("hwr_queue_empty", exp_q.size(), 0);

        // Off-screen host writes are accepted and counted, saturating at 255.
        bus.host_wr_valid = 1'b1; bus.host_wr_addr = 14'(NCELLS); bus.host_wr_data = 8'h33;
        #1;
        chk("drop_ready", 32'(bus.host_wr_ready), 1);
        chk("drop_mem_en", 32'(bus.mem_en), 0);
        tick();
        chk("drop_cnt_1", 32'(bus.drop_cnt), 1);
        for (int i = 0; i < 299; i++) tick();
        bus.host_wr_valid = 1'b0;
        #1;
        chk("drop_cnt_sat", 32'(bus.drop_cnt), 255);

`ifdef CHAR_MEM_CLS_EN
        // Clear wins over a simultaneous host write. Then run a full clear.
        bus.host_wr_valid = 1'b1; bus.host_wr_addr = 14'd50; bus.host_wr_data = 8'h55;
        bus.cls_start = 1'b1;
        #1;
        chk("cls_vs_host_ready", 32'(bus.host_wr_ready), 0);
        tick(); bus.cls_start = 1'b0; bus.host_wr_valid = 1'b0;
        #1;
        chk("cls_busy_start", 32'(bus.cls_busy), 1);
        for (int t = 0; t < 12000 && !bus.cls_done; t++) tick();
        chk("cls_done_seen", 32'(bus.cls_done), 1);
        tick();
        chk("cls_wr_count", clr_wr_cnt, NCELLS);
        chk("cls_wr_sequence", clr_seq_err, 0);
        chk("cls_busy_cycles", busy_cnt, NCELLS);
        tick();
        chk("cls_done_pulses", done_cnt, 1);
        chk("cls_busy_end", 32'(bus.cls_busy), 0);
        bad = 0;
        for (int i = 0; i < NCELLS; i++) if (ram[i] !== FILL) bad++;
        chk("cls_cells_filled", bad, 0);

        // Clear with a fetch every 4th cycle.
        fill_seed = 8'hC3; fill_req = 1'b1;
        tick(); fill_req = 1'b0;
        for (int i = 0; i < 16384; i++) model_mem[i] = pat(i, 8'hC3);
        bus.cls_start = 1'b1;
        tick(); bus.cls_start = 1'b0;
        nfetch = 0;
        for (int t = 0; t < 16000 && !bus.cls_done; t++) begin
            if (t % 4 == 3) begin
                a = $urandom_range(0, NCELLS - 1);
                bus.vid_req = 1'b1; bus.vid_addr = 14'(a);
                push_fetch((a < clr_wr_cnt) ? FILL : model_mem[a]);
                nfetch++;
            end else begin
                bus.vid_req = 1'b0;
            end
            tick();
        end
        bus.vid_req = 1'b0;
        tick(); tick(); tick();
        chk("stall_queue_empty", exp_q.size(), 0);
        chk("stall_done_pulses", done_cnt, 1);
        chk("stall_wr_count", clr_wr_cnt, NCELLS);
        chk("stall_wr_sequence", clr_seq_err, 0);
        chk("stall_busy_cycles", busy_cnt, NCELLS + nfetch);
        bad = 0;
        for (int i = 0; i < NCELLS; i++) if (ram[i] !== FILL) bad++;
        chk("stall_cells_filled", bad, 0);

        // Reset in the middle of a clear, with a fetch in flight.
        bus.cls_start = 1'b1;
        tick(); bus.cls_start = 1'b0;
        for (int t = 0; t < 2000 && clr_wr_cnt < 1000; t++) tick();
        chk("abort_ptr", clr_wr_cnt, 1000);
        bus.vid_req = 1'b1; bus.vid_addr = 14'd7; push_fetch(FILL);
        tick(); bus.vid_req = 1'b0;
        clr = 1'b1; exp_q.delete(); expc_q.delete();
        #1;
        reset_checks("abort");
        tick(); clr = 1'b0;
        #1;
        chk("abort_ready", 32'(bus.host_wr_ready), 1);
        tick(); tick(); tick(); tick();
        chk("abort_no_done", done_cnt, 0);
        chk("abort_busy", 32'(bus.cls_busy), 0);
        chk("abort_no_valid", 32'(bus.vid_valid), 0);
`else
        // Without the clear feature, cls_start neither blocks the host nor starts anything.
        bus.host_wr_valid = 1'b1; bus.host_wr_addr = 14'd50; bus.host_wr_data = 8'h55;
        bus.cls_start = 1'b1;
        #1;
        chk("nocls_ready", 32'(bus.host_wr_ready), 1);
        chk("nocls_mem_we", 32'(bus.mem_we), 1);
        tick(); bus.cls_start = 1'b0; bus.host_wr_valid = 1'b0; model_mem[50] = 8'h55;
        chk("nocls_ram50", 32'(ram[50]), 32'h55);
        for (int t = 0; t < 20; t++) tick();
        chk("nocls_busy", busy_cnt, 0);
        chk("nocls_done", done_cnt, 0);

        // Reset with a fetch in flight.
        bus.vid_req = 1'b1; bus.vid_addr = 14'd50; push_fetch(model_rd(50));
        tick(); bus.vid_req = 1'b0;
        clr = 1'b1; exp_q.delete(); expc_q.delete();
        #1;
        reset_checks("abort");
        tick(); clr = 1'b0;
        #1;
        chk("abort_ready", 32'(bus.host_wr_ready), 1);
        tick(); tick(); tick(); tick();
        chk("abort_no_valid", 32'(bus.vid_valid), 0);
`endif
        chk("final_queue_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/char_mem_ctrl.md
CHAR_MEM_CTRL -- requirements
Module: char_mem_ctrl

Interface
REQ-001 Parameters SHALL be: COLS default 160 (text columns, 4-px cells); ROWS default 60 (text rows, 8-px cells); ADDR_W default 14 (cell address width); FILL_CHAR default 8'h20 (clear-screen fill code).
REQ-002 Ports SHALL be:
- clk, input, 1: clock.
- clr, input, 1: reset, asynchronous, active-high.
- vid_req, input, 1: video fetch request.
- vid_addr, input, ADDR_W: video fetch cell address.
- vid_data, output, 8: fetched char code.
- vid_valid, output, 1: vid_data valid.
- host_wr_valid, input, 1: host write offered.
- host_wr_ready, output, 1: host write accepted this cycle.
- host_wr_addr, input, ADDR_W: host write cell address.
- host_wr_data, input, 8: host char code.
- cls_start, input, 1: clear-screen command.
- cls_busy, output, 1: clear in progress.
- cls_done, output, 1: clear complete pulse.
- drop_cnt, output, 8: dropped host writes.
- mem_en, output, 1: RAM enable.
- mem_we, output, 1: RAM write enable.
- mem_addr, output, ADDR_W: RAM address.
- mem_wdata, output, 8: RAM write data.
- mem_rdata, input, 8: RAM read data, 1-cycle synchronous latency.

Function
REQ-003 Single-port RAM SHALL be shared; per-cycle priority: video > clear > host; at most one access per cycle.
REQ-004 NCELLS = COLS*ROWS; valid addresses 0..NCELLS-1.
REQ-005 vid_req in cycle N with vid_addr < NCELLS: mem_en=1, mem_we=0, mem_addr=vid_addr in N; vid_data registered from mem_rdata at end of N+1; vid_valid=1 in N+2 only (latency 2); vid_data holds until next fetch.
REQ-006 vid_req with vid_addr >= NCELLS: no RAM access; vid_valid=1 in N+2 with vid_data=8'h00.
REQ-007 Back-to-back vid_req every cycle: fully pipelined, one vid_valid per request, order preserved.
REQ-008 host_wr_ready SHALL be combinational: 1 iff state IDLE, vid_req=0, cls_start=0, clr=0.
REQ-009 Transfer = host_wr_valid & host_wr_ready; in-range transfer: mem_en=1, mem_we=1, mem_addr=host_wr_addr, mem_wdata=host_wr_data same cycle.
REQ-010 Out-of-range transfer: accepted, no RAM access, drop_cnt +1, saturating at 255.
REQ-011 FSM states IDLE, CLEAR; IDLE->CLEAR on cls_start (ptr<=0, cls_busy=1 next cycle); cls_start in CLEAR ignored.
REQ-012 CLEAR: each cycle without vid_req writes FILL_CHAR to ptr, ptr+1; vid_req cycles stall clear (ptr unchanged).
REQ-013 Write to ptr=NCELLS-1 -> IDLE next cycle; cls_done=1 for exactly that cycle; cls_busy=0.
REQ-014 cls_start and host_wr_valid same cycle in IDLE: clear wins; host not accepted.
REQ-015 Idle cycles: mem_en=0, mem_we=0; mem_addr/mem_wdata hold last value.

Reset
REQ-016 clr SHALL immediately force: state IDLE, ptr 0, vid_data 0, vid_valid 0, cls_busy 0, cls_done 0, drop_cnt 0, mem_en 0, mem_we 0, mem_addr 0, mem_wdata 0.
REQ-017 clr during CLEAR SHALL abort without cls_done; in-flight video fetches discarded (no vid_valid after release).

Configuration
REQ-018 Macro CHAR_MEM_CLS_EN: defined -> clear sequencer per REQ-011..014; undefined -> no FSM/ptr logic, cls_start ignored, cls_busy and cls_done tied 0, host arbitration ignores cls_start.

Verification
REQ-019 vid_req at addr 5, RAM[5]=8'h41 -> mem_addr=5 same cycle, vid_valid=1 two cycles later with vid_data=8'h41.
REQ-020 vid_req and host_wr_valid (addr 10, data 8'h7A) together -> host_wr_ready=0; next cycle without vid_req -> write accepted, RAM[10]=8'h7A.
REQ-021 host write to addr 9600 (defaults) -> host_wr_ready=1, mem_en=0, drop_cnt 0->1; 300 such writes -> drop_cnt=255.
REQ-022 cls_start, no video traffic -> 9600 consecutive FILL_CHAR writes to 0..9599, cls_done one-cycle pulse, cls_busy 1 for exactly 9600 cycles.
REQ-023 Clear with vid_req every 4th cycle -> clear stalls, all fetches return valid data at latency 2, all cells still 8'h20 at done.
REQ-024 clr asserted at ptr=1000 -> all outputs 0 immediately, no cls_done, host_wr_ready=1 after release with vid_req=0.
